fetch_seq: RTL and testbench

Instruction-fetch sequencer for the code RAM. It owns the program counter that drives the code RAM's `pc` input and captures the returned instruction into a one-entry output register. It hands instructions to decode over a valid/ready handshake, redirects on branches, and detects end-of-program. It sits between the code RAM and the decode stage and is the only driver of the code RAM address.

---
 rtl/fetch_seq_if.sv | 36 +++
 rtl/fetch_seq.sv | 121 ++++++++++++
 tb/tb_fetch_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// Bundle of the fetch sequencer's code-RAM, decode-handshake, branch and status signals.
// master = fetch_seq side, slave = code RAM / decode / branch environment.
`ifndef PCWIDTH
`define PCWIDTH 8
`endif
`ifndef INSWIDTH
`define INSWIDTH 16
`endif

interface fetch_seq_if #(
    parameter int unsigned PCW  = `PCWIDTH,
    parameter int unsigned INSW = `INSWIDTH
);
    logic            start;
    logic [PCW-1:0]  pc_out;
    logic [INSW-1:0] ins_in;
    logic            out_valid;
    logic            out_ready;
    logic [INSW-1:0] out_ins;
    logic [PCW-1:0]  out_pc;
    logic            br_valid;
    logic [PCW-1:0]  br_target;
    logic            busy;
    logic            done;
    logic [15:0]     fetched;

    modport master (
        input  start, ins_in, out_ready, br_valid, br_target,
        output pc_out, out_valid, out_ins, out_pc, busy, done, fetched
    );

    modport slave (
        output start, ins_in, out_ready, br_valid, br_target,
        input  pc_out, out_valid, out_ins, out_pc, busy, done, fetched
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: drives the code-RAM address, buffers one fetched
// instruction for decode, handles branch redirects and end-of-program.
`ifndef PCWIDTH
`define PCWIDTH 8
`endif
`ifndef INSWIDTH
`define INSWIDTH 16
`endif
`ifndef NOP
`define NOP 4'hF
`endif
`ifndef R0
`define R0 4'h0
`endif
`ifndef RESTINSWIDTH
`define RESTINSWIDTH 8
`endif

module fetch_seq #(
    parameter int unsigned PCW      = `PCWIDTH,
    parameter int unsigned INSW     = `INSWIDTH,
    parameter int unsigned CODESIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    fetch_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [INSW-1:0] NOP_WORD = {`NOP, `R0, `RESTINSWIDTH'd0};

    state_t          state, state_d;
    logic [PCW-1:0]  pc;
    logic [PCW-1:0]  ins_pc;
    logic [INSW-1:0] ins;
    logic            valid;
    logic [15:0]     fetch_count;

    logic do_start, do_capture, do_branch, do_retire;
    logic handshake, br_in_range, last_pc;

    assign handshake   = valid & bus.out_ready;
    assign br_in_range = 32'(bus.br_target) < CODESIZE;
    assign last_pc     = 32'(pc) == CODESIZE - 1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_branch  = 1'b0;
        do_retire  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    do_start = 1'b1;
                end
            end
            RUN, DRAIN: begin
                // A redirect outranks both capture and stall.
                if (bus.br_valid) begin
                    do_branch = 1'b1;
                    state_d   = br_in_range ? RUN : DRAIN;
                end else if (!valid || bus.out_ready) begin
                    if (state == RUN) begin
                        do_capture = 1'b1;
                        if (last_pc) state_d = DRAIN;
                    end else begin
                        do_retire = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            valid       <= 1'b0;
            ins_pc      <= '0;
            ins         <= NOP_WORD;
            fetch_count <= '0;
        end else if (do_start) begin
            pc          <= '0;
            valid       <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (do_branch) begin
                pc    <= bus.br_target;
                valid <= 1'b0;
            end else if (do_capture) begin
                ins    <= bus.ins_in;
                ins_pc <= pc;
                valid  <= 1'b1;
                pc     <= pc + PCW'(1);
            end else if (do_retire) begin
                valid <= 1'b0;
            end
            // A handshake flushed by a same-cycle branch is not counted.
            if (handshake && !bus.br_valid && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
        end
    end

    assign bus.pc_out    = pc;
    assign bus.out_valid = valid;
    assign bus.out_ins   = ins;
    assign bus.out_pc    = ins_pc;
    assign bus.fetched   = fetch_count;
    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: scoreboard of expected (pc, instruction) pairs
// popped on every decode handshake, plus status checks after key edges.
`ifndef PCWIDTH
`define PCWIDTH 8
`endif
`ifndef INSWIDTH
`define INSWIDTH 16
`endif
`ifndef NOP
`define NOP 4'hF
`endif
`ifndef R0
`define R0 4'h0
`endif
`ifndef RESTINSWIDTH
`define RESTINSWIDTH 8
`endif

module tb_fetch_seq;
    localparam int unsigned PCW      = `PCWIDTH;
    localparam int unsigned INSW     = `INSWIDTH;
    localparam int unsigned CODESIZE = 8;
    localparam logic [INSW-1:0] NOP_WORD = {`NOP, `R0, `RESTINSWIDTH'd0};

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [INSW-1:0] ins;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    fetch_seq_if #(.PCW(PCW), .INSW(INSW)) bus ();

    fetch_seq #(.PCW(PCW), .INSW(INSW), .CODESIZE(CODESIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Code RAM model: word at address a is 0x10 + a, NOP beyond the program.
    assign bus.ins_in = (32'(bus.pc_out) < CODESIZE) ? INSW'(32'h10 + 32'(bus.pc_out)) : NOP_WORD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int a = lo; a <= hi; a++) begin
            e.pc  = PCW'(a);
            e.ins = INSW'(32'h10 + 32'(a));
            sb.push_back(e);
        end
    endtask

    // One clock cycle: drive at a falling edge, score any handshake, wait for the next falling edge.
    task automatic cyc(input logic rdy, input logic br, input logic [PCW-1:0] tgt,
                       input logic st, input logic r);
        exp_t e;
        rst           = r;
        bus.out_ready = rdy;
        bus.br_valid  = br;
        bus.br_target = tgt;
        bus.start     = st;
        #1;
        if (!r && !br && rdy && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected: observed out_pc %0h expected no handshake", bus.out_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", 32'(bus.out_pc), 32'(e.pc));
                check("sb_ins", 32'(bus.out_ins), 32'(e.ins));
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = '0;
        @(negedge clk);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);

        check("rst_pc_out", 32'(bus.pc_out), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", 32'(bus.out_pc), 32'd0);
        check("rst_out_ins", 32'(bus.out_ins), 32'(NOP_WORD));
        check("rst_fetched", 32'(bus.fetched), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        // Branch request in IDLE has no effect.
        cyc(1'b1, 1'b1, PCW'(5), 1'b0, 1'b0);
        check("idle_br_pc", 32'(bus.pc_out), 32'd0);
        check("idle_br_busy", 32'(bus.busy), 32'd0);

        // Straight run, ready tied high.
        push_range(0, 7);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_pc0", 32'(bus.pc_out), 32'd0);
        check("t1_valid0", 32'(bus.out_valid), 32'd0);
        run(8);
        check("t1_drain_busy", 32'(bus.busy), 32'd1);
        check("t1_drain_done", 32'(bus.done), 32'd0);
        check("t1_drain_out_pc", 32'(bus.out_pc), 32'd7);
        run(1);
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_valid_end", 32'(bus.out_valid), 32'd0);
        check("t1_fetched", 32'(bus.fetched), 32'd8);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Stall for 3 cycles while pc 2 is held.
        push_range(0, 7);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("t2_fetched_clr", 32'(bus.fetched), 32'd0);
        run(3);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
            check("t2_hold_out_pc", 32'(bus.out_pc), 32'd2);
            check("t2_hold_pc_out", 32'(bus.pc_out), 32'd3);
            check("t2_hold_ins", 32'(bus.out_ins), 32'h12);
            check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        for (int k = 0; k < 20 && bus.done !== 1'b1; k++) run(1);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_fetched", 32'(bus.fetched), 32'd8);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Branch to 5 while pc 1 is offered and ready is high: pc 1 is flushed.
        push_range(0, 0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        run(2);
        check("t3_out_pc1", 32'(bus.out_pc), 32'd1);
        push_range(5, 7);
        cyc(1'b1, 1'b1, PCW'(5), 1'b0, 1'b0);
        check("t3_flush_valid", 32'(bus.out_valid), 32'd0);
        check("t3_target_pc", 32'(bus.pc_out), 32'd5);
        check("t3_busy", 32'(bus.busy), 32'd1);
        run(1);
        check("t3_target_out", 32'(bus.out_pc), 32'd5);
        check("t3_target_valid", 32'(bus.out_valid), 32'd1);
        run(3);
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_fetched", 32'(bus.fetched), 32'd4);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Branch in DRAIN back to 0, then an out-of-range branch ends the program.
        push_range(0, 6);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        run(8);
        check("t4_drain_out_pc", 32'(bus.out_pc), 32'd7);
        push_range(0, 1);
        cyc(1'b1, 1'b1, PCW'(0), 1'b0, 1'b0);
        check("t4_rerun_busy", 32'(bus.busy), 32'd1);
        check("t4_rerun_done", 32'(bus.done), 32'd0);
        check("t4_rerun_valid", 32'(bus.out_valid), 32'd0);
        check("t4_rerun_pc", 32'(bus.pc_out), 32'd0);
        run(3);
        check("t4_out_pc2", 32'(bus.out_pc), 32'd2);
        cyc(1'b1, 1'b1, PCW'(9), 1'b0, 1'b0);
        check("t4_oor_valid", 32'(bus.out_valid), 32'd0);
        check("t4_oor_pc", 32'(bus.pc_out), 32'd9);
        check("t4_oor_busy", 32'(bus.busy), 32'd1);
        check("t4_oor_not_done", 32'(bus.done), 32'd0);
        run(1);
        check("t4_oor_done", 32'(bus.done), 32'd1);
        check("t4_fetched", 32'(bus.fetched), 32'd9);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Handshake counter saturation, preloaded just below the limit.
        push_range(0, 7);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("t6_fetched_clr", 32'(bus.fetched), 32'd0);
        run(1);
        force dut.fetch_count = 16'hFFFE;
        run(1);
        release dut.fetch_count;
        run(2);
        check("t6_sat", 32'(bus.fetched), 32'hFFFF);
        run(5);
        check("t6_done", 32'(bus.done), 32'd1);
        check("t6_sat_hold", 32'(bus.fetched), 32'hFFFF);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        // start during RUN is ignored; rst mid-run (with start) wins.
        push_range(0, 0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        run(1);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("t5_ign_pc_out", 32'(bus.pc_out), 32'd2);
        check("t5_ign_out_pc", 32'(bus.out_pc), 32'd1);
        check("t5_ign_valid", 32'(bus.out_valid), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_pc_out", 32'(bus.pc_out), 32'd0);
        check("t5_rst_out_pc", 32'(bus.out_pc), 32'd0);
        check("t5_rst_ins", 32'(bus.out_ins), 32'(NOP_WORD));
        check("t5_rst_fetched", 32'(bus.fetched), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
